// File: rtl/vga_timing_pkg.sv
// Shared timing types, 640x480@60 defaults and small helpers for the VGA raster generator.
package vga_timing_pkg;

    // One raster axis: visible extent followed by front porch, sync pulse and back porch.
    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } axis_timing_t;

    localparam axis_timing_t H_DEFAULT = '{visible: 640, front: 16, sync: 96, back: 48};
    localparam axis_timing_t V_DEFAULT = '{visible: 480, front: 10, sync: 2, back: 33};

    localparam int unsigned DEFAULT_SCALE_SHIFT = 1;
    localparam int unsigned FRAME_CNT_W         = 16;

    // Length of one full axis period in counter steps.
    function automatic int unsigned axis_total(axis_timing_t t);
        return t.visible + t.front + t.sync + t.back;
    endfunction

    // Coordinate width for a scaled extent; never narrower than one bit.
    function automatic int unsigned pos_width(int unsigned extent);
        return (extent <= 1) ? 1 : $clog2(extent);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster outputs from the timing generator towards the renderer and the VGA connector.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int unsigned X_W = 9,
    parameter int unsigned Y_W = 8
);
    logic                   hsync_o;
    logic                   vsync_o;
    logic                   visible_o;
    logic [X_W-1:0]         position_x_o;
    logic [Y_W-1:0]         position_y_o;
    logic                   line_start_o;
    logic                   frame_start_o;
    logic [FRAME_CNT_W-1:0] frame_count_o;

    modport master (
        output hsync_o, vsync_o, visible_o, position_x_o, position_y_o,
               line_start_o, frame_start_o, frame_count_o
    );

    modport slave (
        input hsync_o, vsync_o, visible_o, position_x_o, position_y_o,
              line_start_o, frame_start_o, frame_count_o
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible and sync decode.
// count_o, wrap_o and visible_o describe the value being loaded at the coming edge, so the
// parent can register anything derived from them in step with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter axis_timing_t TIMING   = H_DEFAULT,
    parameter bit           SYNC_POL = 1'b0,
    localparam int unsigned TOTAL    = axis_total(TIMING),
    localparam int unsigned CNT_W    = $clog2(TOTAL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             advance_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o,
    output logic             visible_o,
    output logic             sync_o
);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam int unsigned      SYNC_START = TIMING.visible + TIMING.front;
    localparam int unsigned      SYNC_END   = SYNC_START + TIMING.sync;

    if (TIMING.visible == 0 || TIMING.front == 0 || TIMING.sync == 0 || TIMING.back == 0)
    begin : g_bad_timing
        $error("vga_axis_counter: visible, porch and sync extents must be non-zero");
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_q, sync_d;

    assign wrap_o = advance_i && (count_q == LAST);

    // Next count and its decode.
    always_comb begin
        count_d = count_q;
        if (advance_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
        visible_o = 32'(count_d) < TIMING.visible;
        sync_d    = ((32'(count_d) >= SYNC_START) && (32'(count_d) < SYNC_END)) ? SYNC_POL
                                                                               : ~SYNC_POL;
    end

    // Counter and registered sync level; position 0 is never inside the sync pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_d;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advancing on a pixel-clock enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = H_DEFAULT.visible,
    parameter int unsigned H_FRONT     = H_DEFAULT.front,
    parameter int unsigned H_SYNC      = H_DEFAULT.sync,
    parameter int unsigned H_BACK      = H_DEFAULT.back,
    parameter int unsigned V_VISIBLE   = V_DEFAULT.visible,
    parameter int unsigned V_FRONT     = V_DEFAULT.front,
    parameter int unsigned V_SYNC      = V_DEFAULT.sync,
    parameter int unsigned V_BACK      = V_DEFAULT.back,
    parameter bit          H_SYNC_POL  = 1'b0,
    parameter bit          V_SYNC_POL  = 1'b0,
    parameter int unsigned SCALE_SHIFT = DEFAULT_SCALE_SHIFT,
    localparam int unsigned X_W        = pos_width(H_VISIBLE >> SCALE_SHIFT),
    localparam int unsigned Y_W        = pos_width(V_VISIBLE >> SCALE_SHIFT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pixel_en_i,
    vga_timing_gen_if.master vga_o
);

    localparam axis_timing_t H_TIMING =
        '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam axis_timing_t V_TIMING =
        '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int unsigned  H_CNT_W  = $clog2(axis_total(H_TIMING));
    localparam int unsigned  V_CNT_W  = $clog2(axis_total(V_TIMING));

    if (SCALE_SHIFT > 3) begin : g_bad_scale
        $error("vga_timing_gen: SCALE_SHIFT must be in 0..3");
    end

    logic [H_CNT_W-1:0] h_count;
    logic [V_CNT_W-1:0] v_count;
    logic               h_wrap, v_wrap, h_visible, v_visible, hsync, vsync;

    vga_axis_counter #(
        .TIMING   (H_TIMING),
        .SYNC_POL (H_SYNC_POL)
    ) u_h_axis (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (pixel_en_i),
        .count_o   (h_count),
        .wrap_o    (h_wrap),
        .visible_o (h_visible),
        .sync_o    (hsync)
    );

    // The vertical axis steps once per completed line.
    vga_axis_counter #(
        .TIMING   (V_TIMING),
        .SYNC_POL (V_SYNC_POL)
    ) u_v_axis (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (h_wrap),
        .count_o   (v_count),
        .wrap_o    (v_wrap),
        .visible_o (v_visible),
        .sync_o    (vsync)
    );

    logic                   visible_q, visible_d;
    logic [X_W-1:0]         pos_x_q, pos_x_d;
    logic [Y_W-1:0]         pos_y_q, pos_y_d;
    logic                   line_start_q, line_start_d;
    logic                   frame_start_q, frame_start_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    // Decode positions and strobes from the counter values about to be loaded.
    always_comb begin
        visible_d     = h_visible && v_visible;
        pos_x_d       = visible_d ? X_W'(h_count >> SCALE_SHIFT) : '0;
        pos_y_d       = visible_d ? Y_W'(v_count >> SCALE_SHIFT) : '0;
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
        frame_count_d = frame_start_d ? frame_count_q + FRAME_CNT_W'(1) : frame_count_q;
    end

    // Output registers; reset puts the raster at (0,0), which is visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            visible_q     <= 1'b1;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            visible_q     <= visible_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vga_o.hsync_o       = hsync;
    assign vga_o.vsync_o       = vsync;
    assign vga_o.visible_o     = visible_q;
    assign vga_o.position_x_o  = pos_x_q;
    assign vga_o.position_y_o  = pos_y_q;
    assign vga_o.line_start_o  = line_start_q;
    assign vga_o.frame_start_o = frame_start_q;
    assign vga_o.frame_count_o = frame_count_q;

endmodule
